// File: rtl/siso_pkg.sv
// Shared definitions for the serial-out frame controller: FSM state codes
// and the counter-width helper used for bit_idx and the gap counter.
package siso_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_PARITY = 2'd2;
  localparam logic [STATE_W-1:0] ST_GAP    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY,
    GAP    = ST_GAP
  } state_t;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Producer handshake plus serial-side status of the frame controller.
// master = word producer, slave = siso_frame_ctrl.
interface siso_frame_ctrl_if
  import siso_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     serial_out;
  logic                     frame_active;
  logic                     frame_done;
  logic [cnt_w(DATA_W)-1:0] bit_idx;

  modport master (
    output in_data, in_valid,
    input  in_ready, serial_out, frame_active, frame_done, bit_idx
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, serial_out, frame_active, frame_done, bit_idx
  );

endinterface

// File: rtl/siso_load_shift.sv
// Parallel-load, MSB-first shift register; zeros enter at the LSB.
module siso_load_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              msb
);

  logic [DATA_W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = load_data;
    end else if (shift) begin
      sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb = sreg_q[DATA_W-1];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Frame controller: accepts words, serializes them MSB-first and enforces an
// idle gap between frames. Define SISO_FRAME_PARITY_EN to append a parity bit.
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  siso_frame_ctrl_if.slave bus
);

  localparam int BIT_W = cnt_w(DATA_W);
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              serial_out_q, serial_out_d;
  logic              frame_active_q, frame_active_d;
  logic              frame_done_q, frame_done_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              load_en, shift_en, end_frame, next_bit;
  logic [DATA_W-1:0] load_word;
`ifdef SISO_FRAME_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // The MSB goes straight to serial_out on accept, so the register holds
  // the remaining bits pre-shifted and its MSB is always the next bit due.
  assign load_word = {bus.in_data[DATA_W-2:0], 1'b0};

  siso_load_shift #(.DATA_W(DATA_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .shift     (shift_en),
    .load_data (load_word),
    .msb       (next_bit)
  );

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    serial_out_d   = 1'b0;
    frame_active_d = 1'b0;
    frame_done_d   = 1'b0;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    load_en        = 1'b0;
    shift_en       = 1'b0;
    end_frame      = 1'b0;
`ifdef SISO_FRAME_PARITY_EN
    parity_d       = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!in_ready_q) begin
          in_ready_d = 1'b1;
        end else if (bus.in_valid) begin
          load_en        = 1'b1;
          in_ready_d     = 1'b0;
          state_d        = SHIFT;
          serial_out_d   = bus.in_data[DATA_W-1];
          frame_active_d = 1'b1;
          bit_cnt_d      = BIT_MAX;
`ifdef SISO_FRAME_PARITY_EN
          parity_d       = ^bus.in_data;
`endif
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt_q != '0) begin
          serial_out_d   = next_bit;
          frame_active_d = 1'b1;
          bit_cnt_d      = bit_cnt_q - BIT_W'(1);
        end else begin
`ifdef SISO_FRAME_PARITY_EN
          state_d        = PARITY;
          serial_out_d   = parity_q;
          frame_active_d = 1'b1;
`else
          end_frame      = 1'b1;
`endif
        end
      end
`ifdef SISO_FRAME_PARITY_EN
      PARITY: begin
        end_frame = 1'b1;
      end
`endif
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
    endcase

    // With no gap configured the controller is ready again in the done cycle.
    if (end_frame) begin
      frame_done_d = 1'b1;
      if (GAP_CYCLES > 0) begin
        state_d   = GAP;
        gap_cnt_d = GAP_LOAD;
      end else begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      serial_out_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      serial_out_q   <= serial_out_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

`ifdef SISO_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign bus.in_ready     = in_ready_q;
  assign bus.serial_out   = serial_out_q;
  assign bus.frame_active = frame_active_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.bit_idx      = bit_cnt_q;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench for siso_frame_ctrl: two instances (GAP_CYCLES=1 and 0) checked each
// cycle against a frame-timeline model; SISO_FRAME_PARITY_EN is honoured.
module tb_siso_frame_ctrl;

  localparam int DW = 8;
`ifdef SISO_FRAME_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  typedef struct packed {
    logic       ser;
    logic       act;
    logic       done;
    logic       rdy;
    logic [2:0] idx;
  } obs_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    obs_t       exp;
  } vec_t;

  logic clk;
  logic reset;

  siso_frame_ctrl_if #(.DATA_W(DW)) bus1 ();
  siso_frame_ctrl_if #(.DATA_W(DW)) bus0 ();

  siso_frame_ctrl #(.DATA_W(DW), .GAP_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  siso_frame_ctrl #(.DATA_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  obs_t cur1, cur0;
  obs_t q1[$];
  obs_t q0[$];
  bit   acc1_evt, acc0_evt;
  vec_t tbl[$];

  int          acc, n1, ph1, gap1, ph0, gap0;
  bit          dr0;
  logic [31:0] got1;
  logic        rv;
  logic [7:0]  rd;

  function automatic obs_t idleObs();
    obs_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  function automatic obs_t obs1();
    obs_t o;
    o.ser  = bus1.serial_out;
    o.act  = bus1.frame_active;
    o.done = bus1.frame_done;
    o.rdy  = bus1.in_ready;
    o.idx  = bus1.bit_idx;
    return o;
  endfunction

  function automatic obs_t obs0();
    obs_t o;
    o.ser  = bus0.serial_out;
    o.act  = bus0.frame_active;
    o.done = bus0.frame_done;
    o.rdy  = bus0.in_ready;
    o.idx  = bus0.bit_idx;
    return o;
  endfunction

  function automatic logic [31:0] appendWord(input logic [31:0] acc_in, input logic [7:0] w);
    logic [31:0] r;
    r = acc_in;
    for (int i = DW - 1; i >= 0; i--) r = {r[30:0], w[i]};
`ifdef SISO_FRAME_PARITY_EN
    r = {r[30:0], ^w};
`endif
    return r;
  endfunction

  task automatic pushRec(input int which, input obs_t r);
    if (which == 1) q1.push_back(r);
    else q0.push_back(r);
  endtask

  // Timeline of the cycles following an accept: data bits, optional parity,
  // the done cycle, then the gap cycles; ready returns on the last of them.
  task automatic pushFrame(input int which, input int gap, input logic [7:0] d);
    obs_t r;
    for (int i = DW - 1; i >= 0; i--) begin
      r = '0; r.ser = d[i]; r.act = 1'b1; r.idx = 3'(i);
      pushRec(which, r);
    end
`ifdef SISO_FRAME_PARITY_EN
    r = '0; r.ser = ^d; r.act = 1'b1;
    pushRec(which, r);
`endif
    r = '0; r.done = 1'b1; r.rdy = (gap == 0);
    pushRec(which, r);
    for (int g = 1; g <= gap; g++) begin
      r = '0; r.rdy = (g == gap);
      pushRec(which, r);
    end
  endtask

  task automatic modelReset();
    q1.delete();
    q0.delete();
    cur1 = '0;
    cur0 = '0;
    acc1_evt = 1'b0;
    acc0_evt = 1'b0;
  endtask

  task automatic modelEdge(input logic v, input logic [7:0] d);
    acc1_evt = v && cur1.rdy;
    acc0_evt = v && cur0.rdy;
    if (acc1_evt) pushFrame(1, 1, d);
    if (acc0_evt) pushFrame(0, 0, d);
    cur1 = (q1.size() > 0) ? q1.pop_front() : idleObs();
    cur0 = (q0.size() > 0) ? q0.pop_front() : idleObs();
  endtask

  task automatic compareObs(input string tag, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got ser=%0b act=%0b done=%0b rdy=%0b idx=%0d, required ser=%0b act=%0b done=%0b rdy=%0b idx=%0d",
               tag, got.ser, got.act, got.done, got.rdy, got.idx,
               exp.ser, exp.act, exp.done, exp.rdy, exp.idx);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    compareObs({tag, "/gap1"}, obs1(), cur1);
    compareObs({tag, "/gap0"}, obs0(), cur0);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input string tag);
    bus1.in_valid = v;
    bus1.in_data  = d;
    bus0.in_valid = v;
    bus0.in_data  = d;
    @(posedge clk);
    if (!reset) modelReset();
    else modelEdge(v, d);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic addRow(input logic v, input logic [7:0] d, input logic ser,
                        input logic act, input logic done, input logic rdy, input int idx);
    vec_t r;
    r.v = v; r.d = d;
    r.exp.ser = ser; r.exp.act = act; r.exp.done = done; r.exp.rdy = rdy;
    r.exp.idx = 3'(idx);
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    bus0.in_valid = 1'b0; bus0.in_data = '0;

    // Reset release, then 8'hB5 on the GAP_CYCLES=1 instance (valid during
    // the frame must be ignored).
    addRow(0, 8'h00, 0, 0, 0, 1, 0);
    addRow(0, 8'h00, 0, 0, 0, 1, 0);
    addRow(1, 8'hB5, 1, 1, 0, 0, 7);
    addRow(1, 8'hFF, 0, 1, 0, 0, 6);
    addRow(0, 8'h00, 1, 1, 0, 0, 5);
    addRow(0, 8'h00, 1, 1, 0, 0, 4);
    addRow(0, 8'h00, 0, 1, 0, 0, 3);
    addRow(0, 8'h00, 1, 1, 0, 0, 2);
    addRow(0, 8'h00, 0, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0);
`ifdef SISO_FRAME_PARITY_EN
    addRow(0, 8'h00, 1, 1, 0, 0, 0);
`endif
    addRow(0, 8'h00, 0, 0, 1, 0, 0);
    addRow(0, 8'h00, 0, 0, 0, 1, 0);
    addRow(0, 8'h00, 0, 0, 0, 1, 0);

    #2 reset = 1'b0;
    #1 modelReset();
    checkOutput("reset");
    @(negedge clk);
    applyStimulus(0, 8'h00, "reset_hold");
    reset = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, $sformatf("vec%0d", i));
      compareObs($sformatf("table%0d", i), obs1(), tbl[i].exp);
    end

    // Back-to-back with valid held: A5 then 3C.
    acc = 0; got1 = '0; n1 = 0; ph1 = 0; gap1 = 0; ph0 = 0; gap0 = 0; dr0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(acc < 2, (acc == 0) ? 8'hA5 : 8'h3C, "b2b");
      if (acc1_evt) acc++;
      if (bus1.frame_active) begin
        got1 = {got1[30:0], bus1.serial_out};
        n1++;
      end
      if (ph1 == 0 && bus1.frame_active) ph1 = 1;
      else if (ph1 == 1 && !bus1.frame_active) begin ph1 = 2; gap1 = 1; end
      else if (ph1 == 2) begin
        if (bus1.frame_active) ph1 = 3;
        else gap1++;
      end
      if (ph0 == 0 && bus0.frame_active) ph0 = 1;
      else if (ph0 == 1 && !bus0.frame_active) begin ph0 = 2; gap0 = 1; end
      else if (ph0 == 2) begin
        if (bus0.frame_active) ph0 = 3;
        else gap0++;
      end
      if (bus0.frame_done && bus0.in_ready) dr0 = 1'b1;
    end
    checkValue("b2b_stream", got1, appendWord(appendWord(32'h0, 8'hA5), 8'h3C));
    checkValue("b2b_bitcount", 32'(n1), 32'(2 * FLEN));
    checkValue("b2b_gap1", 32'(gap1), 32'd2);
    checkValue("b2b_gap0", 32'(gap0), 32'd1);
    checkValue("gap0_done_and_ready", 32'(dr0), 32'd1);

    for (int c = 0; c < 4; c++) applyStimulus(0, 8'h00, "idle");

    // Abort 8'hFF after three bits with an asynchronous reset.
    applyStimulus(1, 8'hFF, "abort_acc");
    applyStimulus(0, 8'h00, "abort_b1");
    applyStimulus(0, 8'h00, "abort_b2");
    #2 reset = 1'b0;
    #1 modelReset();
    checkOutput("abort_async");
    applyStimulus(0, 8'h00, "abort_hold");
    applyStimulus(0, 8'h00, "abort_hold");
    reset = 1'b1;
    applyStimulus(0, 8'h00, "abort_rel");
    got1 = '0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c == 0, 8'h81, "after_abort");
      if (bus1.frame_active) begin
        got1 = {got1[30:0], bus1.serial_out};
        n1++;
      end
    end
    checkValue("after_abort_stream", got1, appendWord(32'h0, 8'h81));
    checkValue("after_abort_bitcount", 32'(n1), 32'(FLEN));

    for (int c = 0; c < 400; c++) begin
      rv = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      applyStimulus(rv, rd, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siso_frame_ctrl.md
Name: siso_frame_ctrl

Overview:
Controller that sequences a serial-out shift path. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto serial_out, one bit per clock. It enforces a programmable idle gap between frames and flags frame activity and completion. It sits upstream of serial links or chained serial-in/serial-out registers and is the single owner of the shift datapath.

Parameters:
DATA_W, 8, word width in bits (>=2)
GAP_CYCLES, 1, idle cycles with serial_out=0 after each frame, before the next accept (0 allowed)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
in_data  input  DATA_W  parallel word, sampled on accept
in_valid  input  1  producer has a word
in_ready  output  1  controller can accept (registered)
serial_out  output  1  serialized bit stream (registered)
frame_active  output  1  high while serial_out carries a frame bit
frame_done  output  1  one-cycle pulse after the last frame bit
bit_idx  output  $clog2(DATA_W)  index of the data bit currently on serial_out (DATA_W-1 down to 0)

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=0, serial_out=0, frame_active=0, frame_done=0, bit_idx=0, shift register=0, counters=0.
- First rising edge after reset release: in_ready<=1. No accept is possible on that edge.
- Accept: rising edge k with in_valid=1 and in_ready=1. in_data is loaded, in_ready<=0, state<=SHIFT.
- SHIFT: from edge k+i to edge k+i+1 (i=0..DATA_W-1), serial_out=in_data[DATA_W-1-i], bit_idx=DATA_W-1-i, frame_active=1.
- End of frame, edge k+DATA_W: serial_out<=0, frame_active<=0, frame_done<=1 for exactly one cycle.
  - If GAP_CYCLES>0: state<=GAP.
  - If GAP_CYCLES=0: state<=IDLE and in_ready<=1.
- GAP: serial_out=0 for GAP_CYCLES cycles, then state<=IDLE and in_ready<=1. The earliest next accept is edge k+DATA_W+GAP_CYCLES+1.
- in_data and in_valid are ignored whenever in_ready=0. A producer holding in_valid does not stall the controller.
- Back-to-back: with in_valid held high, frames repeat with exactly GAP_CYCLES+1 non-frame cycles between them.
- Reset mid-frame: the frame is aborted immediately. All outputs take reset values, and there is no frame_done pulse.
- frame_done and in_ready may both be 1 in the same cycle (GAP_CYCLES=0 case).
- Bit counter: DATA_W-1 down to 0, no wrap. Reaching 0 in SHIFT ends the data phase.
- State encoding: IDLE, SHIFT, PARITY (optional), GAP. Unreachable codes return to IDLE.

Optional Feature:
SISO_FRAME_PARITY_EN
- Defined: after the last data bit, a PARITY state drives serial_out = even-parity bit (XOR of all data bits) for one cycle with frame_active=1 and bit_idx=0. frame_done and the GAP phase shift one cycle later; frame length is DATA_W+1.
- Undefined: the PARITY state and its logic are absent; frame length is DATA_W.

Decomposition:
- Package siso_pkg: state encodings (IDLE/SHIFT/PARITY/GAP localparams), STATE_W, and a clog2-based counter width constant/function for bit_idx and the gap counter.
- Sub-module siso_load_shift: DATA_W parallel-load, MSB-first shift register with load/shift enables and the async active-low reset.
- siso_frame_ctrl keeps the FSM, bit/gap counters, handshake and optional parity.

Test Plan:
- Reset release, in_valid=0 -> in_ready=1 one edge after release; serial_out=0, frame_active=0, frame_done=0 indefinitely.
- Accept 8'hB5 (DATA_W=8, GAP=1) -> serial_out 1,0,1,1,0,1,0,1 on 8 consecutive cycles; bit_idx 7..0; frame_done one-cycle pulse; in_ready=1 two edges after the last bit.
- in_valid held high, words 8'hA5 then 8'h3C -> streams 10100101 then 00111100, separated by exactly 2 non-frame cycles; second word sampled only when in_ready=1.
- GAP_CYCLES=0, two words -> frame_done and in_ready high together; second frame starts one cycle after the first ends.
- Assert reset after 3 bits of 8'hFF -> all outputs 0 asynchronously, no frame_done; after release, new word 8'h81 serializes cleanly as 10000001.
- SISO_FRAME_PARITY_EN defined: 8'hB5 -> 9 bits, parity bit 1; 8'h00 -> 9 zeros, parity 0; frame_done one cycle later than without the macro.
